// File: rtl/fetch_top_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and instruction memory (slave).
interface fetch_top_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32
);
  logic                  imem_req;
  logic [ADDR_SIZE-1:0]  imem_addr;
  logic                  imem_ready;
  logic [INSTR_SIZE-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/fetch_top.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, redirect/squash and a one-entry
// hold buffer that absorbs decode stalls.
module fetch_top #(
  parameter int                    ADDR_SIZE  = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = 32'h0000_1000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  fetch_top_if.master           imem,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] out_instruction,
  output logic                  out_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_SIZE-1:0]    pc_q, pc_d;
  logic [ADDR_SIZE-1:0]    addr_q, addr_d;
  logic [ADDR_SIZE-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_SIZE-1:0]   out_instr_q, out_instr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [ADDR_SIZE-1:0]    buf_pc_q, buf_pc_d;
  logic [INSTR_SIZE-1:0]   buf_instr_q, buf_instr_d;
  logic [ADDR_SIZE-1:0]    redirect_pc_q, redirect_pc_d;
  logic                    redirect_pending_q, redirect_pending_d;

  logic                    req;
  logic                    resp;
  logic                    jump_accept;
  logic                    redirect;
  logic [ADDR_SIZE-1:0]    redirect_target;
  logic [ADDR_SIZE-1:0]    seq_pc;

  // A jump counts only when decode actually takes it, so a stalled jump redirects exactly once.
  assign jump_accept     = is_jump && out_valid_q && !stall;
  assign redirect        = branch_taken || jump_accept;
  assign redirect_target = branch_taken ? branch_addr : jump_addr;
  assign req             = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign resp            = (state_q == S_REQ) && imem.imem_ready;
  assign seq_pc          = pc_q + ADDR_SIZE'(4);

  assign imem.imem_req   = req;
  assign imem.imem_addr  = addr_q;
  assign out_pc          = out_pc_q;
  assign out_instruction = out_instr_q;
  assign out_valid       = out_valid_q;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    addr_d             = addr_q;
    out_pc_d           = out_pc_q;
    out_instr_d        = out_instr_q;
    out_valid_d        = out_valid_q;
    buf_valid_d        = buf_valid_q;
    buf_pc_d           = buf_pc_q;
    buf_instr_d        = buf_instr_q;
    redirect_pc_d      = redirect_pc_q;
    redirect_pending_d = redirect_pending_q;

    if (redirect) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
      buf_valid_d = 1'b0;
      pc_d        = redirect_target;
      // An unanswered request must stay on the bus; its answer is dropped in DRAIN.
      if (req && !imem.imem_ready) begin
        redirect_pc_d      = redirect_target;
        redirect_pending_d = 1'b1;
        state_d            = S_DRAIN;
      end else begin
        addr_d             = redirect_target;
        redirect_pending_d = 1'b0;
        state_d            = S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (resp) begin
            pc_d   = seq_pc;
            addr_d = seq_pc;
          end
          if (!stall) begin
            if (buf_valid_q) begin
              out_pc_d    = buf_pc_q;
              out_instr_d = buf_instr_q;
              out_valid_d = 1'b1;
              buf_valid_d = resp;
              buf_pc_d    = addr_q;
              buf_instr_d = imem.imem_data;
            end else if (resp) begin
              out_pc_d    = addr_q;
              out_instr_d = imem.imem_data;
              out_valid_d = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              out_instr_d = NOP_INSTR;
            end
          end else if (resp) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = addr_q;
            buf_instr_d = imem.imem_data;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            out_pc_d    = buf_pc_q;
            out_instr_d = buf_instr_q;
            out_valid_d = buf_valid_q;
            buf_valid_d = 1'b0;
            addr_d      = pc_q;
            state_d     = S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect_pending_q && imem.imem_ready) begin
            addr_d             = redirect_pc_q;
            pc_d               = redirect_pc_q;
            redirect_pending_d = 1'b0;
            state_d            = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      pc_q               <= RESET_PC;
      addr_q             <= RESET_PC;
      out_pc_q           <= RESET_PC;
      out_instr_q        <= NOP_INSTR;
      out_valid_q        <= 1'b0;
      buf_valid_q        <= 1'b0;
      buf_pc_q           <= '0;
      buf_instr_q        <= '0;
      redirect_pc_q      <= RESET_PC;
      redirect_pending_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      addr_q             <= addr_d;
      out_pc_q           <= out_pc_d;
      out_instr_q        <= out_instr_d;
      out_valid_q        <= out_valid_d;
      buf_valid_q        <= buf_valid_d;
      buf_pc_q           <= buf_pc_d;
      buf_instr_q        <= buf_instr_d;
      redirect_pc_q      <= redirect_pc_d;
      redirect_pending_q <= redirect_pending_d;
    end
  end

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: cycle-exact vector table, reset-in-DRAIN sequence, and a randomized run
// checked against a program-order model of the instruction stream decode should receive.
module tb_fetch_top;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_top_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) imem ();

  fetch_top #(
    .ADDR_SIZE(32), .INSTR_SIZE(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .is_jump(is_jump), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .imem(imem),
    .out_pc(out_pc), .out_instruction(out_instruction), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Memory contents are a pure function of the address, so any word's expected value is known.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ a[31:16]};
  endfunction

  assign imem.imem_data = mem_word(imem.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        stall;
    logic        jmp;
    logic [31:0] jaddr;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int s, input int j, input logic [31:0] ja, input int b,
                              input logic [31:0] ba, input int r, input int er,
                              input logic [31:0] ea, input int ev, input logic [31:0] ep);
    vec_t v;
    v.stall = (s != 0);  v.jmp = (j != 0);  v.jaddr = ja;
    v.br = (b != 0);     v.baddr = ba;      v.rdy = (r != 0);
    v.e_req = (er != 0); v.e_addr = ea;     v.e_valid = (ev != 0); v.e_pc = ep;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
    check({tag, " imem_req"}, {31'b0, imem.imem_req}, {31'b0, e_req});
    check({tag, " imem_addr"}, imem.imem_addr, e_addr);
    check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
    if (e_valid) begin
      check({tag, " out_pc"}, out_pc, e_pc);
      check({tag, " out_instruction"}, out_instruction, mem_word(e_pc));
    end else begin
      check({tag, " out_instruction NOP"}, out_instruction, NOP);
    end
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] ja, input logic b,
                       input logic [31:0] ba, input logic r);
    stall = s; is_jump = j; jump_addr = ja; branch_taken = b; branch_addr = ba;
    imem.imem_ready = r;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic        prev_wait;
  int          delivered;

  initial begin
    imem.imem_ready = 1'b0;

    // Row i lists the inputs applied during cycle i and the outputs visible in that cycle.
    vecs.push_back(mk(0,0,0,0,0,1, 0,32'h1000,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h1000,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h1004,1,32'h1000));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h1004,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h1004,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h1004,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h1008,1,32'h1004));
    vecs.push_back(mk(1,0,0,0,0,1, 1,32'h100C,1,32'h1008));
    vecs.push_back(mk(1,0,0,0,0,1, 0,32'h1010,1,32'h1008));
    vecs.push_back(mk(1,0,0,0,0,1, 0,32'h1010,1,32'h1008));
    vecs.push_back(mk(1,0,0,0,0,1, 0,32'h1010,1,32'h1008));
    vecs.push_back(mk(0,0,0,0,0,1, 0,32'h1010,1,32'h1008));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h1010,1,32'h100C));
    vecs.push_back(mk(1,1,32'h2000,0,0,1, 1,32'h1014,1,32'h1010));
    vecs.push_back(mk(0,1,32'h2000,0,0,1, 0,32'h1018,1,32'h1010));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h2000,0,0));
    vecs.push_back(mk(0,1,32'h2100,0,0,1, 1,32'h2004,1,32'h2000));
    vecs.push_back(mk(0,0,0,1,32'h3000,0, 1,32'h2100,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h2100,0,0));
    vecs.push_back(mk(0,0,0,1,32'h3100,0, 1,32'h2100,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h2100,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h3100,0,0));
    vecs.push_back(mk(1,0,0,1,32'h4000,1, 1,32'h3104,1,32'h3100));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h4000,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h4004,1,32'h4000));
    vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFC,1, 1,32'h4004,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h0000_0000,1,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h0000_0004,1,32'h0000_0000));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset imem_req", {31'b0, imem.imem_req}, 32'd0);
    check("reset imem_addr", imem.imem_addr, RESET_PC);
    check("reset out_pc", out_pc, RESET_PC);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_instruction", out_instruction, NOP);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].jmp, vecs[i].jaddr, vecs[i].br, vecs[i].baddr, vecs[i].rdy);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc);
      @(negedge clk);
    end

    // Reset asserted while a redirect is draining an unanswered request.
    drive(1'b0, 1'b0, '0, 1'b1, 32'h5000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    check_outputs("drain", 1'b1, 32'h0000_0004, 1'b0, '0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("async reset", 1'b0, RESET_PC, 1'b0, '0);
    check("async reset out_pc", out_pc, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    imem.imem_ready = 1'b1;
    #1;
    check_outputs("restart idle", 1'b0, RESET_PC, 1'b0, '0);
    @(negedge clk); #1;
    check_outputs("restart req", 1'b1, 32'h1000, 1'b0, '0);
    @(negedge clk); #1;
    check_outputs("restart deliver", 1'b1, 32'h1004, 1'b1, 32'h1000);

    // Randomized run against the program-order model.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_pc    = RESET_PC;
    prev_wait = 1'b0;
    prev_addr = '0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (prev_wait) begin
        check("rand req held", {31'b0, imem.imem_req}, 32'd1);
        check("rand addr held", imem.imem_addr, prev_addr);
      end
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 29) == 0);
      branch_addr  = $urandom & 32'hFFFF_FFFC;
      is_jump      = out_valid && (out_pc[4:2] == 3'd6);
      jump_addr    = ({out_pc[15:0], out_pc[31:16]} ^ 32'h0000_2A40) & 32'hFFFF_FFFC;
      imem.imem_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!out_valid) begin
        check("rand bubble NOP", out_instruction, NOP);
      end else begin
        check("rand out_pc", out_pc, exp_pc);
        check("rand out_instruction", out_instruction, mem_word(exp_pc));
        if (!stall) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      if (branch_taken)
        exp_pc = branch_addr;
      else if (is_jump && out_valid && !stall)
        exp_pc = jump_addr;
      prev_wait = imem.imem_req && !imem.imem_ready;
      prev_addr = imem.imem_addr;
    end
    check("rand progress", {31'b0, (delivered > 500)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
